// File: rtl/tic_tac_toe_move_controller.sv
// tic_tac_toe_move_controller
// Turn sequencer and board owner for a tic-tac-toe game. Arbitrates board
// writes between the player and the computer, presents the candidate square
// to an external combinational illegal-move detector, commits legal moves and
// decides the end of each game.
//
// Optional feature macro: TTT_WIN_DETECT_EN (line-win detection in EVAL).
// Without it a game ends only on a full board with winner = 11 (draw).
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   new_game     synchronous clear of board and FSM, highest priority
//   ply_req      player move request, ply_En_pos one-hot target square
//   pc_req       computer move request, pc_En_pos one-hot target square
//   illegal_move detector verdict on det_En_pos against the board
//   det_En_pos   candidate square, non-zero only in the CHECK states
//   pos1..pos9   board squares: 00 empty, 01 player, 10 computer
//   ply_ack      pulse: player move committed
//   pc_ack       pulse: computer move committed
//   move_err     pulse: current side's move rejected
//   turn         0 player to move, 1 computer to move
//   game_over    level, game finished
//   winner       00 none, 01 player, 10 computer, 11 draw
//   move_cnt     committed moves, 0..9
module tic_tac_toe_move_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       ply_req,
  input  logic [8:0] ply_En_pos,
  input  logic       pc_req,
  input  logic [8:0] pc_En_pos,
  input  logic       illegal_move,
  output logic [8:0] det_En_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       ply_ack,
  output logic       pc_ack,
  output logic       move_err,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_cnt
);

  typedef enum logic [2:0] {PTurn, PCheck, CTurn, CCheck, Eval, Done} state_t;

  state_t     state;
  logic [1:0] board [9];
  logic [8:0] pend;
  logic       pend_onehot;
  logic       line_win;

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign pend_onehot = (pend != 9'd0) && ((pend & (pend - 9'd1)) == 9'd0);

`ifdef TTT_WIN_DETECT_EN
  function automatic logic three(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a != 2'b00) && (a == b) && (b == c);
  endfunction

  always_comb begin
    line_win = three(board[0], board[1], board[2]) ||
               three(board[3], board[4], board[5]) ||
               three(board[6], board[7], board[8]) ||
               three(board[0], board[3], board[6]) ||
               three(board[1], board[4], board[7]) ||
               three(board[2], board[5], board[8]) ||
               three(board[0], board[4], board[8]) ||
               three(board[2], board[4], board[6]);
  end
`else
  assign line_win = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PTurn;
      pend       <= 9'd0;
      det_En_pos <= 9'd0;
      for (int i = 0; i < 9; i++) board[i] <= 2'b00;
      ply_ack    <= 1'b0;
      pc_ack     <= 1'b0;
      move_err   <= 1'b0;
      turn       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      move_cnt   <= 4'd0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      ply_ack  <= 1'b0;
      pc_ack   <= 1'b0;
      move_err <= 1'b0;
      if (new_game) begin
        state      <= PTurn;
        pend       <= 9'd0;
        det_En_pos <= 9'd0;
        for (int i = 0; i < 9; i++) board[i] <= 2'b00;
        turn       <= 1'b0;
        game_over  <= 1'b0;
        winner     <= 2'b00;
        move_cnt   <= 4'd0;
      end else begin
        case (state)
          PTurn: begin
            if (ply_req) begin
              pend       <= ply_En_pos;
              det_En_pos <= ply_En_pos;
              state      <= PCheck;
            end
          end
          CTurn: begin
            if (pc_req) begin
              pend       <= pc_En_pos;
              det_En_pos <= pc_En_pos;
              state      <= CCheck;
            end
          end
          PCheck, CCheck: begin
            det_En_pos <= 9'd0;
            if (illegal_move || !pend_onehot) begin
              move_err <= 1'b1;
              state    <= (state == PCheck) ? PTurn : CTurn;
            end else begin
              for (int i = 0; i < 9; i++) begin
                if (pend[i]) board[i] <= (state == CCheck) ? 2'b10 : 2'b01;
              end
              ply_ack  <= (state == PCheck);
              pc_ack   <= (state == CCheck);
              move_cnt <= move_cnt + 4'd1;
              state    <= Eval;
            end
          end
          Eval: begin
            // turn still names the side that just moved.
            if (line_win) begin
              game_over <= 1'b1;
              winner    <= turn ? 2'b10 : 2'b01;
              state     <= Done;
            end else if (move_cnt == 4'd9) begin
              game_over <= 1'b1;
              winner    <= 2'b11;
              state     <= Done;
            end else begin
              turn  <= ~turn;
              state <= turn ? PTurn : CTurn;
            end
          end
          Done: begin
          end
          default: state <= PTurn;
        endcase
      end
    end
  end

endmodule
